// File: rtl/dac_frame_ctrl_pkg.sv
// Shared constants and sizing helpers for the DAC serial frame controller.
package dac_pkg;

    localparam int unsigned REFRESH_OFF = 0;
    localparam int unsigned REFRESH_ON  = 1;

    // Serial word width: channel index followed by the data bits.
    function automatic int unsigned shift_width(input int unsigned ch_w, input int unsigned dw);
        return ch_w + dw;
    endfunction

endpackage

// File: rtl/dac_frame_ctrl_arbiter.sv
// Combinational round-robin search: first requesting channel after ptr, with wrap.
module dac_rr_arbiter
    import dac_pkg::*;
#(
    parameter int unsigned NCH  = 2,
    parameter int unsigned CH_W = 1
) (
    input  logic [NCH-1:0]  req,
    input  logic [CH_W-1:0] ptr,
    output logic            found,
    output logic [CH_W-1:0] grant
);

    always_comb begin
        int unsigned idx;
        found = 1'b0;
        grant = '0;
        idx   = 0;
        // Offset 1..NCH visits every channel once, ptr itself last.
        for (int unsigned i = 1; i <= NCH; i++) begin
            idx = (32'(ptr) + i) % NCH;
            if (!found && req[CH_W'(idx)]) begin
                found = 1'b1;
                grant = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/dac_frame_ctrl.sv
// Multi-channel DAC frame controller: shadow registers, dirty tracking,
// round-robin channel selection and MSB-first shifting under an active-low SCEn.
module dac_frame_ctrl
    import dac_pkg::*;
#(
    parameter int unsigned NCH       = 2,
    parameter int unsigned CH_W      = 1,
    parameter int unsigned DW        = 8,
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned PRELOAD   = 0,
    parameter int unsigned REFRESH   = REFRESH_OFF
) (
    input  logic            clk_4M,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [CH_W-1:0] wr_ch,
    input  logic [DW-1:0]   wr_data,
    output logic            scen,
    output logic            dout,
    output logic [CH_W-1:0] cur_ch,
    output logic            frame_done,
    output logic            overrun,
    output logic [NCH-1:0]  dirty
);

    localparam int unsigned SW    = shift_width(CH_W, DW);
    localparam int unsigned IDLE  = FRAME_LEN - SW;
    localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] ARM_CNT  = CNT_W'(IDLE - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] cnt;
    logic [CH_W-1:0]  rr_ptr;
    logic [DW-1:0]    shadow [NCH];
    logic [SW-1:0]    shreg;
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   dirty_nxt;
    logic             arb_found;
    logic [CH_W-1:0]  arb_ch;
    logic             arm;
    logic             wr_valid;
    logic             overrun_nxt;

    // In refresh mode every channel requests, so the search lands on ptr+1.
    assign req      = (REFRESH == REFRESH_ON) ? '1 : dirty;
    assign arm      = (cnt == ARM_CNT) && arb_found;
    assign wr_valid = wr_en && (32'(wr_ch) < NCH);

    dac_rr_arbiter #(
        .NCH  (NCH),
        .CH_W (CH_W)
    ) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .found (arb_found),
        .grant (arb_ch)
    );

    // The arm clear is applied first so a same-cycle write re-marks the channel
    // dirty without counting as an overrun.
    always_comb begin
        dirty_nxt   = dirty;
        overrun_nxt = 1'b0;
        if (arm) begin
            dirty_nxt[arb_ch] = 1'b0;
        end
        if (wr_valid) begin
            overrun_nxt        = dirty_nxt[wr_ch];
            dirty_nxt[wr_ch]   = 1'b1;
        end
    end

    always_ff @(posedge clk_4M or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                shadow[i] <= '0;
            end
        end else if (wr_valid) begin
            shadow[wr_ch] <= wr_data;
        end
    end

    always_ff @(posedge clk_4M or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= CNT_W'(PRELOAD);
            rr_ptr  <= CH_W'(NCH - 1);
            dirty   <= '0;
            scen    <= 1'b1;
            cur_ch  <= '0;
            overrun <= 1'b0;
            shreg   <= '0;
        end else begin
            cnt     <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
            dirty   <= dirty_nxt;
            overrun <= overrun_nxt;
            if (arm) begin
                shreg  <= {arb_ch, shadow[arb_ch]};
                cur_ch <= arb_ch;
                rr_ptr <= arb_ch;
                scen   <= 1'b0;
            end else begin
                if (!scen) begin
                    shreg <= shreg << 1;
                end
                if (cnt == LAST_CNT) begin
                    scen <= 1'b1;
                end
            end
        end
    end

    assign dout       = !scen && shreg[SW-1];
    assign frame_done = !scen && (cnt == LAST_CNT);

endmodule

// File: tb/tb_dac_frame_ctrl.sv
// Bench for dac_frame_ctrl: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized writes.
module tb_dac_frame_ctrl;
    import dac_pkg::*;

    localparam int IDLE_C = 7;
    localparam int SW_C   = 9;
    localparam int FL_C   = 16;

    logic clk_4M = 1'b0;
    always #5 clk_4M = ~clk_4M;

    logic rst_na = 1'b1;
    logic rst_nb = 1'b1;
    logic       wen  [2];
    logic       wch  [2];
    logic [7:0] wdat [2];

    logic scen_a, dout_a, cur_ch_a, frame_done_a, overrun_a;
    logic scen_b, dout_b, cur_ch_b, frame_done_b, overrun_b;
    logic [1:0] dirty_a, dirty_b;

    int pass_cnt = 0;
    int total_cnt = 0;
    int ov_a = 0;

    dac_frame_ctrl #(
        .NCH(2), .CH_W(1), .DW(8), .FRAME_LEN(16), .PRELOAD(0), .REFRESH(REFRESH_OFF)
    ) dut_a (
        .clk_4M(clk_4M), .rst_n(rst_na), .wr_en(wen[0]), .wr_ch(wch[0]), .wr_data(wdat[0]),
        .scen(scen_a), .dout(dout_a), .cur_ch(cur_ch_a), .frame_done(frame_done_a),
        .overrun(overrun_a), .dirty(dirty_a)
    );

    dac_frame_ctrl #(
        .NCH(2), .CH_W(1), .DW(8), .FRAME_LEN(16), .PRELOAD(5), .REFRESH(REFRESH_ON)
    ) dut_b (
        .clk_4M(clk_4M), .rst_n(rst_nb), .wr_en(wen[1]), .wr_ch(wch[1]), .wr_data(wdat[1]),
        .scen(scen_b), .dout(dout_b), .cur_ch(cur_ch_b), .frame_done(frame_done_b),
        .overrun(overrun_b), .dirty(dirty_b)
    );

    // Reference model: position in frame, which word (if any) this frame carries.
    int       mcnt   [2];
    int       mptr   [2];
    int       msh    [2][2];
    logic [1:0] mdirty [2];
    bit       marmed [2];
    int       mword  [2];
    int       mch    [2];
    bit       mov    [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset(input int k);
        mcnt[k]   = (k == 0) ? 0 : 5;
        mptr[k]   = 1;
        msh[k][0] = 0;
        msh[k][1] = 0;
        mdirty[k] = 2'b00;
        marmed[k] = 0;
        mword[k]  = 0;
        mch[k]    = 0;
        mov[k]    = 0;
    endtask

    task automatic model_step(input int k);
        int  c;
        int  ch;
        bit  arm;
        c   = mcnt[k];
        arm = 0;
        ch  = 0;
        mov[k] = 0;
        if (c == IDLE_C - 1) begin
            for (int i = 1; i <= 2; i++) begin
                int idx;
                idx = (mptr[k] + i) % 2;
                if (!arm && (k == 1 || mdirty[k][idx])) begin
                    arm = 1;
                    ch  = idx;
                end
            end
            if (arm) begin
                mword[k]  = ch * 256 + msh[k][ch];
                mch[k]    = ch;
                mptr[k]   = ch;
                mdirty[k][ch] = 1'b0;
                marmed[k] = 1;
            end
        end
        if (c == FL_C - 1) marmed[k] = 0;
        if (wen[k]) begin
            if (mdirty[k][wch[k]]) mov[k] = 1;
            msh[k][wch[k]] = int'(wdat[k]);
            mdirty[k][wch[k]] = 1'b1;
        end
        mcnt[k] = (c + 1) % FL_C;
    endtask

    always @(posedge clk_4M or negedge rst_na)
        if (!rst_na) model_reset(0); else model_step(0);
    always @(posedge clk_4M or negedge rst_nb)
        if (!rst_nb) model_reset(1); else model_step(1);

    task automatic cmp(input int k, input logic s, input logic d, input logic cc,
                       input logic fd, input logic ov, input logic [1:0] dm);
        bit    act;
        string p;
        p   = (k == 0) ? "a" : "b";
        act = marmed[k] && mcnt[k] >= IDLE_C;
        chk({p, ".scen"}, 32'(s), 32'(!act));
        chk({p, ".dout"}, 32'(d), act ? 32'((mword[k] >> (SW_C - 1 - (mcnt[k] - IDLE_C))) & 1) : 32'd0);
        chk({p, ".cur_ch"}, 32'(cc), 32'(mch[k]));
        chk({p, ".frame_done"}, 32'(fd), 32'(marmed[k] && mcnt[k] == FL_C - 1));
        chk({p, ".overrun"}, 32'(ov), 32'(mov[k]));
        chk({p, ".dirty"}, 32'(dm), 32'(mdirty[k]));
    endtask

    always @(negedge clk_4M) begin
        cmp(0, scen_a, dout_a, cur_ch_a, frame_done_a, overrun_a, dirty_a);
        cmp(1, scen_b, dout_b, cur_ch_b, frame_done_b, overrun_b, dirty_b);
        if (overrun_a) ov_a++;
    end

    task automatic wait_cnt(input int k, input int c);
        int n;
        n = 0;
        while (mcnt[k] != c && n < 40) begin
            @(negedge clk_4M);
            n++;
        end
        if (mcnt[k] != c) chk("wait_cnt timeout", 32'(mcnt[k]), 32'(c));
    endtask

    task automatic wr(input int k, input int ch, input logic [7:0] d);
        wen[k]  = 1'b1;
        wch[k]  = ch[0];
        wdat[k] = d;
        @(negedge clk_4M);
        wen[k]  = 1'b0;
    endtask

    // Called on the first active count; returns on count 0 of the next frame.
    task automatic cap_word(input int k, output logic [8:0] w, output int lows, output int fds);
        w = '0;
        lows = 0;
        fds = 0;
        for (int j = 0; j < SW_C; j++) begin
            if (k == 0) begin
                w = {w[7:0], dout_a};
                if (!scen_a) lows++;
                if (frame_done_a) fds++;
            end else begin
                w = {w[7:0], dout_b};
                if (!scen_b) lows++;
                if (frame_done_b) fds++;
            end
            @(negedge clk_4M);
        end
    endtask

    initial begin
        logic [8:0] w;
        int lows, fds, base, n;
        logic [8:0] exp_a5;
        for (int k = 0; k < 2; k++) begin
            wen[k] = 1'b0; wch[k] = 1'b0; wdat[k] = '0;
        end
        #1;
        rst_na = 1'b0;
        rst_nb = 1'b0;
        @(negedge clk_4M);
        @(negedge clk_4M);
        rst_na = 1'b1;
        rst_nb = 1'b1;
        chk("reset scen", 32'(scen_a), 32'd1);
        chk("reset dout", 32'(dout_a), 32'd0);
        chk("reset dirty", 32'(dirty_a), 32'd0);
        chk("reset cur_ch", 32'(cur_ch_a), 32'd0);

        // No writes: three silent frames.
        lows = 0; fds = 0;
        for (int j = 0; j < 3 * FL_C; j++) begin
            if (!scen_a) lows++;
            if (frame_done_a) fds++;
            @(negedge clk_4M);
        end
        chk("idle scen lows", 32'(lows), 32'd0);
        chk("idle frame_done", 32'(fds), 32'd0);

        // ch1 = 0xA5 written at count 2.
        wait_cnt(0, 2);
        wr(0, 1, 8'hA5);
        chk("a5 dirty after write", 32'(dirty_a), 32'd2);
        wait_cnt(0, 6);
        chk("a5 scen before arm", 32'(scen_a), 32'd1);
        wait_cnt(0, 7);
        exp_a5 = 9'b1_1010_0101;
        cap_word(0, w, lows, fds);
        chk("a5 word", 32'(w), 32'(exp_a5));
        chk("a5 lows", 32'(lows), 32'd9);
        chk("a5 frame_done", 32'(fds), 32'd1);
        chk("a5 scen at count 0", 32'(scen_a), 32'd1);
        chk("a5 dirty cleared", 32'(dirty_a), 32'd0);

        // Two writes in one idle window go out in successive frames.
        wait_cnt(0, 1);
        wr(0, 0, 8'h11);
        wr(0, 1, 8'h22);
        wait_cnt(0, 7);
        cap_word(0, w, lows, fds);
        chk("rr first word", 32'(w), 32'h011);
        wait_cnt(0, 7);
        chk("rr second cur_ch", 32'(cur_ch_a), 32'd1);
        cap_word(0, w, lows, fds);
        chk("rr second word", 32'(w), 32'h122);

        // Double write before arm: one overrun, last write sent once.
        wait_cnt(0, 1);
        base = ov_a;
        wr(0, 0, 8'h55);
        wr(0, 0, 8'h33);
        wait_cnt(0, 7);
        cap_word(0, w, lows, fds);
        chk("overrun word", 32'(w), 32'h033);
        lows = 0;
        for (int j = 0; j < FL_C; j++) begin
            if (!scen_a) lows++;
            @(negedge clk_4M);
        end
        chk("no resend", 32'(lows), 32'd0);
        chk("overrun pulses", 32'(ov_a - base), 32'd1);

        // Write on the arm cycle: old value goes out, new one next frame.
        wait_cnt(0, 1);
        base = ov_a;
        wr(0, 0, 8'h10);
        wait_cnt(0, 6);
        wr(0, 0, 8'h20);
        chk("arm-write dirty kept", 32'(dirty_a), 32'd1);
        cap_word(0, w, lows, fds);
        chk("arm-write old word", 32'(w), 32'h010);
        wait_cnt(0, 7);
        cap_word(0, w, lows, fds);
        chk("arm-write new word", 32'(w), 32'h020);
        chk("arm-write dirty clear", 32'(dirty_a), 32'd0);
        chk("arm-write no overrun", 32'(ov_a - base), 32'd0);

        // Refresh instance: async reset during bit 4, restart from preload.
        wr(1, 0, 8'hC3);
        wait_cnt(1, 11);
        chk("b scen mid frame", 32'(scen_b), 32'd0);
        #1;
        rst_nb = 1'b0;
        #1;
        chk("b scen async reset", 32'(scen_b), 32'd1);
        chk("b dout async reset", 32'(dout_b), 32'd0);
        @(negedge clk_4M);
        @(negedge clk_4M);
        rst_nb = 1'b1;
        n = 0;
        while (mcnt[1] != 7 && n < 40) begin
            if (!scen_b) lows++;
            @(negedge clk_4M);
            n++;
        end
        chk("b cycles to first frame", 32'(n), 32'd2);
        chk("b first scen", 32'(scen_b), 32'd0);
        chk("b first cur_ch", 32'(cur_ch_b), 32'd0);
        cap_word(1, w, lows, fds);
        chk("b first word", 32'(w), 32'h000);
        wait_cnt(1, 7);
        cap_word(1, w, lows, fds);
        chk("b second word", 32'(w), 32'h100);

        // Randomized writes on both instances.
        for (int j = 0; j < 800; j++) begin
            for (int k = 0; k < 2; k++) begin
                wen[k]  = ($urandom_range(0, 3) == 0);
                wch[k]  = 1'($urandom_range(0, 1));
                wdat[k] = 8'($urandom);
            end
            @(negedge clk_4M);
        end
        wen[0] = 1'b0;
        wen[1] = 1'b0;
        repeat (2 * FL_C) @(negedge clk_4M);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
